// File: rtl/add_header_v2.sv
// Packet header inserter: buffers AXI-Stream packets, measures them on input,
// and emits one header beat (bytes, beats, seq, sat) ahead of each packet.
module add_header_v2 #(
    parameter int DW         = 128,
    parameter int DATA_DEPTH = 1024,
    parameter int PLEN_DEPTH = 64,
    parameter int LEN_W      = 16
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [DW-1:0]                 axis_data_tdata,
    input  logic [DW/8-1:0]               axis_data_tkeep,
    input  logic                          axis_data_tlast,
    input  logic                          axis_data_tvalid,
    output logic                          axis_data_tready,
    output logic [DW-1:0]                 axis_out_tdata,
    output logic [DW/8-1:0]               axis_out_tkeep,
    output logic                          axis_out_tlast,
    output logic                          axis_out_tvalid,
    input  logic                          axis_out_tready,
    output logic [$clog2(PLEN_DEPTH):0]   pkts_buffered
);
    localparam int KW  = DW / 8;
    localparam int DA  = $clog2(DATA_DEPTH);
    localparam int PA  = $clog2(PLEN_DEPTH);
    localparam int DFW = DW + KW + 1;
    localparam int HW  = 2 * LEN_W + 17;
    localparam int CW  = $clog2(KW + 1);
    localparam logic [LEN_W-1:0] LEN_MAX = '1;
    localparam logic [DA:0] DATA_FULL = DATA_DEPTH[DA:0];
    localparam logic [PA:0] PLEN_FULL = PLEN_DEPTH[PA:0];

    typedef enum logic {S_HDR, S_PKT} state_t;

    function automatic logic [CW-1:0] popcnt(input logic [KW-1:0] k);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < KW; i++) c = c + CW'(k[i]);
        return c;
    endfunction

    logic [DFW-1:0]   data_mem [DATA_DEPTH];
    logic [DA:0]      data_wr, data_rd, data_cnt;
    logic [HW-1:0]    plen_mem [PLEN_DEPTH];
    logic [PA:0]      plen_wr, plen_rd, plen_cnt;
    logic             data_full, data_empty, plen_full, plen_empty;
    logic             data_push, data_pop, plen_push, plen_pop;
    logic [DFW-1:0]   data_head;
    logic [HW-1:0]    plen_head, hdr_entry;
    logic [DW-1:0]    hdr_word;

    logic [LEN_W-1:0] byte_acc, beat_acc, byte_nxt, beat_nxt;
    logic [LEN_W:0]   byte_sum, beat_sum;
    logic             sat, sat_nxt;
    logic [15:0]      seq;
    state_t           state, state_nxt;

    assign data_cnt   = data_wr - data_rd;
    assign plen_cnt   = plen_wr - plen_rd;
    assign data_full  = (data_cnt == DATA_FULL);
    assign plen_full  = (plen_cnt == PLEN_FULL);
    assign data_empty = (data_cnt == '0);
    assign plen_empty = (plen_cnt == '0);
    assign data_head  = data_mem[data_rd[DA-1:0]];
    assign plen_head  = plen_mem[plen_rd[PA-1:0]];

    assign axis_data_tready = resetn && !data_full && !plen_full;
    assign data_push = axis_data_tvalid && axis_data_tready;
    assign plen_push = data_push && axis_data_tlast;
    assign pkts_buffered = resetn ? plen_cnt : '0;

    // Saturating byte/beat sums including the beat currently offered
    always_comb begin
        byte_sum  = {1'b0, byte_acc} + (LEN_W + 1)'(popcnt(axis_data_tkeep));
        beat_sum  = {1'b0, beat_acc} + (LEN_W + 1)'(1);
        byte_nxt  = byte_sum[LEN_W] ? LEN_MAX : byte_sum[LEN_W-1:0];
        beat_nxt  = beat_sum[LEN_W] ? LEN_MAX : beat_sum[LEN_W-1:0];
        sat_nxt   = sat | byte_sum[LEN_W] | beat_sum[LEN_W];
        hdr_entry = {sat_nxt, seq, beat_nxt, byte_nxt};
    end

    // Header word layout built from the header FIFO head
    always_comb begin
        hdr_word          = '0;
        hdr_word[LEN_W-1:0] = plen_head[LEN_W-1:0];
        hdr_word[16+:LEN_W] = plen_head[LEN_W+:LEN_W];
        hdr_word[47:32]   = plen_head[2*LEN_W+:16];
        hdr_word[48]      = plen_head[HW-1];
    end

    // FIFO storage; contents need no reset since pointers gate visibility
    always_ff @(posedge clk) begin
        if (data_push)
            data_mem[data_wr[DA-1:0]] <= {axis_data_tlast, axis_data_tkeep, axis_data_tdata};
        if (plen_push)
            plen_mem[plen_wr[PA-1:0]] <= hdr_entry;
    end

    // FIFO pointers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            data_wr <= '0;
            data_rd <= '0;
            plen_wr <= '0;
            plen_rd <= '0;
        end else begin
            if (data_push) data_wr <= data_wr + 1'b1;
            if (data_pop)  data_rd <= data_rd + 1'b1;
            if (plen_push) plen_wr <= plen_wr + 1'b1;
            if (plen_pop)  plen_rd <= plen_rd + 1'b1;
        end
    end

    // Per-packet accumulators and header sequence number
    always_ff @(posedge clk) begin
        if (!resetn) begin
            byte_acc <= '0;
            beat_acc <= '0;
            sat      <= 1'b0;
            seq      <= '0;
        end else if (data_push) begin
            if (axis_data_tlast) begin
                byte_acc <= '0;
                beat_acc <= '0;
                sat      <= 1'b0;
                seq      <= seq + 16'd1;
            end else begin
                byte_acc <= byte_nxt;
                beat_acc <= beat_nxt;
                sat      <= sat_nxt;
            end
        end
    end

    // Output FSM state register
    always_ff @(posedge clk) begin
        if (!resetn) state <= S_HDR;
        else         state <= state_nxt;
    end

    // Output mux: header beat first, then packet data up to tlast
    always_comb begin
        state_nxt       = state;
        axis_out_tdata  = '0;
        axis_out_tkeep  = '0;
        axis_out_tlast  = 1'b0;
        axis_out_tvalid = 1'b0;
        data_pop        = 1'b0;
        plen_pop        = 1'b0;
        if (resetn) begin
            unique case (state)
                S_HDR: begin
                    axis_out_tdata  = hdr_word;
                    axis_out_tkeep  = '1;
                    axis_out_tvalid = !plen_empty;
                    plen_pop        = !plen_empty && axis_out_tready;
                    if (plen_pop) state_nxt = S_PKT;
                end
                S_PKT: begin
                    {axis_out_tlast, axis_out_tkeep, axis_out_tdata} = data_head;
                    axis_out_tvalid = !data_empty;
                    data_pop        = !data_empty && axis_out_tready;
                    if (data_pop && data_head[DFW-1]) state_nxt = S_HDR;
                end
                default: state_nxt = S_HDR;
            endcase
        end
    end
endmodule
